// File: rtl/velocity_tick_gen.sv
// Speed tick generator for the delivery game velocity selector.
// Shared prescaler feeding seven dividers, gated by a run/hold/idle FSM.
module velocity_tick_gen #(
    parameter int unsigned PRESCALE = 250000,
    parameter int unsigned DIV0     = 16,
    parameter int unsigned DIV1     = 12,
    parameter int unsigned DIV2     = 10,
    parameter int unsigned DIV3     = 8,
    parameter int unsigned DIV4     = 6,
    parameter int unsigned DIV5     = 5,
    parameter int unsigned DIV6     = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    input  logic restart,
    output logic v0,
    output logic v1,
    output logic v2,
    output logic v3,
    output logic v4,
    output logic v5,
    output logic v6,
    output logic running
);

    localparam int unsigned PW =
        (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam logic [4:0] D_LAST [7] = '{
        5'(DIV0 - 1), 5'(DIV1 - 1), 5'(DIV2 - 1),
        5'(DIV3 - 1), 5'(DIV4 - 1), 5'(DIV5 - 1),
        5'(DIV6 - 1)
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   presc;
    logic [4:0]      div_q [7];
    logic            base;
    logic            clear;
    logic [6:0]      hit;
    logic [6:0]      v_q;

    // Next-state logic; restart always wins over run.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (!restart && run) state_nx = RUN;
            RUN: begin
                if (restart)   state_nx = IDLE;
                else if (!run) state_nx = HOLD;
            end
            HOLD: begin
                if (restart)  state_nx = IDLE;
                else if (run) state_nx = RUN;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register; running tracks the state it is entering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_nx;
            running <= (state_nx == RUN);
        end
    end

    assign base  = (presc == P_LAST);
    assign clear = restart || (state == IDLE);

    // Hit decode: a divider at its last phase on a base strobe in RUN.
    always_comb begin
        hit = '0;
        for (int k = 0; k < 7; k++) begin
            hit[k] = (state == RUN) && base &&
                     (div_q[k] == D_LAST[k]);
        end
    end

    // Prescaler: cleared on idle/restart, frozen on hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else if (clear) begin
            presc <= '0;
        end else if (state == RUN) begin
            presc <= base ? '0 : presc + PW'(1);
        end
    end

    // Dividers advance once per base strobe while running.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 7; k++) div_q[k] <= '0;
        end else if (clear) begin
            for (int k = 0; k < 7; k++) div_q[k] <= '0;
        end else if (state == RUN && base) begin
            for (int k = 0; k < 7; k++) begin
                div_q[k] <= (div_q[k] == D_LAST[k]) ?
                            5'd0 : div_q[k] + 5'd1;
            end
        end
    end

    // Register the hits so each tick is a clean one-cycle strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) v_q <= '0;
        else          v_q <= hit;
    end

    assign v0 = v_q[0];
    assign v1 = v_q[1];
    assign v2 = v_q[2];
    assign v3 = v_q[3];
    assign v4 = v_q[4];
    assign v5 = v_q[5];
    assign v6 = v_q[6];

endmodule

// File: tb/tb_velocity_tick_gen.sv
// Bench for velocity_tick_gen with PRESCALE=4 and default dividers.
// Reference model counts RUN cycles since the last phase reset.
module tb_velocity_tick_gen;

    localparam int P = 4;
    localparam int D [7] = '{16, 12, 10, 8, 6, 5, 4};

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic run = 1'b0;
    logic restart = 1'b0;
    logic v0, v1, v2, v3, v4, v5, v6, running;
    logic [6:0] v;

    int checks = 0;
    int errors = 0;

    typedef enum int {M_IDLE, M_RUN, M_HOLD} mstate_t;
    mstate_t ms = M_IDLE;
    int          n = 0;
    logic [6:0]  ev = '0;
    logic        er = 1'b0;

    velocity_tick_gen #(
        .PRESCALE(P),
        .DIV0(16), .DIV1(12), .DIV2(10), .DIV3(8),
        .DIV4(6), .DIV5(5), .DIV6(4)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .run(run), .restart(restart),
        .v0(v0), .v1(v1), .v2(v2), .v3(v3),
        .v4(v4), .v5(v5), .v6(v6),
        .running(running)
    );

    assign v = {v6, v5, v4, v3, v2, v1, v0};

    always #5 clock = ~clock;

    task automatic model_reset();
        ms = M_IDLE;
        n  = 0;
        ev = '0;
        er = 1'b0;
    endtask

    // Drive inputs for one cycle, advance the model, land on negedge.
    task automatic step(input logic r, input logic rs);
        mstate_t old;
        run = r;
        restart = rs;
        @(posedge clock);
        old = ms;
        ev = '0;
        if (ms == M_RUN) begin
            n++;
            for (int k = 0; k < 7; k++)
                if (n % (D[k] * P) == 0) ev[k] = 1'b1;
        end
        case (ms)
            M_IDLE: if (!rs && r) ms = M_RUN;
            M_RUN:  if (rs) ms = M_IDLE;
                    else if (!r) ms = M_HOLD;
            default: if (rs) ms = M_IDLE;
                     else if (r) ms = M_RUN;
        endcase
        if (rs || old == M_IDLE) n = 0;
        er = (ms == M_RUN);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        run = 1'b0;
        restart = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({v, running} !== 8'h00) begin
            errors++;
            $display("FAIL reset got %b exp %b", {v, running}, 8'h00);
        end
        reset_n = 1'b1;
        step(1'b0, 1'b0);
        checks++;
        if ({v, running} !== {ev, er}) begin
            errors++;
            $display("FAIL reset_idle got %b exp %b",
                     {v, running}, {ev, er});
        end
    endtask

    task automatic test_run_ticks();
        logic [6:0] want;
        do_reset();
        step(1'b1, 1'b0);
        for (int c = 0; c <= 140; c++) begin
            if (c > 0) step(1'b1, 1'b0);
            checks++;
            if ({v, running} !== {ev, er}) begin
                errors++;
                $display("FAIL run c=%0d got %b exp %b",
                         c, {v, running}, {ev, er});
            end
            want = '0;
            for (int k = 0; k < 7; k++)
                if (c > 0 && c % (D[k] * P) == 0) want[k] = 1'b1;
            checks++;
            if (v !== want || running !== 1'b1) begin
                errors++;
                $display("FAIL run_sched c=%0d got %b/%b exp %b/1",
                         c, v, running, want);
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        step(1'b1, 1'b0);
        for (int c = 1; c <= 30; c++) step(1'b1, 1'b0);
        for (int c = 31; c <= 40; c++) begin
            step(1'b0, 1'b0);
            checks++;
            if ({v, running} !== {ev, er} || running !== 1'b0) begin
                errors++;
                $display("FAIL hold c=%0d got %b exp %b",
                         c, {v, running}, {ev, er});
            end
        end
        for (int c = 41; c <= 70; c++) begin
            step(1'b1, 1'b0);
            checks++;
            if ({v, running} !== {ev, er}) begin
                errors++;
                $display("FAIL hold_resume c=%0d got %b exp %b",
                         c, {v, running}, {ev, er});
            end
            if (c == 42) begin
                checks++;
                if (v6 !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_v6_42 got %b exp 1", v6);
                end
            end
        end
    endtask

    task automatic test_restart();
        do_reset();
        step(1'b1, 1'b0);
        for (int c = 1; c <= 40; c++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        checks++;
        if ({v, running} !== {ev, er} || running !== 1'b0) begin
            errors++;
            $display("FAIL restart_idle got %b exp %b",
                     {v, running}, {ev, er});
        end
        step(1'b1, 1'b0);
        for (int c = 0; c <= 70; c++) begin
            if (c > 0) step(1'b1, 1'b0);
            checks++;
            if ({v, running} !== {ev, er}) begin
                errors++;
                $display("FAIL restart c=%0d got %b exp %b",
                         c, {v, running}, {ev, er});
            end
            if (c < 16) begin
                checks++;
                if (v !== 7'd0) begin
                    errors++;
                    $display("FAIL restart_quiet c=%0d got %b exp 0",
                             c, v);
                end
            end
            if (c == 16 || c == 64) begin
                checks++;
                if (v6 !== 1'b1 || (c == 64 && v0 !== 1'b1)) begin
                    errors++;
                    $display("FAIL restart_first c=%0d got %b", c, v);
                end
            end
        end
    endtask

    task automatic test_idle_lock();
        do_reset();
        for (int c = 0; c < 40; c++) begin
            step(1'b1, 1'b1);
            checks++;
            if ({v, running} !== 8'h00) begin
                errors++;
                $display("FAIL idle_lock c=%0d got %b exp 0",
                         c, {v, running});
            end
        end
    endtask

    task automatic test_async_reset();
        int guard;
        do_reset();
        step(1'b1, 1'b0);
        guard = 0;
        while (ev == 7'd0 && guard < 100) begin
            step(1'b1, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("FAIL async_wait got timeout exp tick");
        end
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({v, running} !== 8'h00) begin
            errors++;
            $display("FAIL async_drop got %b exp 0", {v, running});
        end
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1, 1'b0);
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) step(1'b1, 1'b0);
            checks++;
            if ({v, running} !== {ev, er} ||
                v6 !== (c == 16)) begin
                errors++;
                $display("FAIL async_rerun c=%0d got %b exp %b",
                         c, {v, running}, {ev, er});
            end
        end
    endtask

    task automatic test_random();
        logic r;
        logic rs;
        do_reset();
        r = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0) r = ~r;
            rs = ($urandom_range(0, 149) == 0);
            step(r, rs);
            checks++;
            if ({v, running} !== {ev, er}) begin
                errors++;
                $display("FAIL random c=%0d got %b exp %b",
                         c, {v, running}, {ev, er});
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_ticks();
        test_hold();
        test_restart();
        test_idle_lock();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
